// File: rtl/fifo_nw_1r.sv
// fifo_nw_1r: single-clock FIFO accepting 0..WR_LANES entries per cycle and popping one.
// Revision: 1.0
`default_nettype none

module fifo_nw_1r #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_LANES      = 2,
  parameter int AF_MARGIN     = 2,
  parameter int CNT_W         = $clog2(WR_LANES + 1)
) (
  input  logic                           Clk,
  input  logic                           Clear_in,
  input  logic [WR_LANES*DATA_WIDTH-1:0] Data_in,
  input  logic [CNT_W-1:0]               WriteCnt_in,
  output logic                           Full_out,
  output logic                           Almost_full_out,
  output logic                           Overflow_out,
  input  logic                           stall,
  input  logic                           ReadEn_in,
  output logic [DATA_WIDTH-1:0]          Data_out,
  output logic                           Data_valid,
  output logic                           Empty_out,
  output logic [ADDRESS_WIDTH:0]         Count_out
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH+1:0] c_depth    = (ADDRESS_WIDTH+2)'(DEPTH);
  localparam logic [ADDRESS_WIDTH+1:0] c_lanes_w  = (ADDRESS_WIDTH+2)'(WR_LANES);
  localparam logic [ADDRESS_WIDTH+1:0] c_af_level = (ADDRESS_WIDTH+2)'(AF_MARGIN + WR_LANES);
  localparam logic [CNT_W-1:0]         c_lanes    = CNT_W'(WR_LANES);

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0]    r_dout;
  logic                     r_dvalid;
  logic                     r_ovf;

  logic [ADDRESS_WIDTH+1:0] w_free;
  logic                     w_full;
  logic [CNT_W-1:0]         w_wr_n;
  logic                     w_rd_fire;

  // Flags depend only on the registered count, so no input reaches an output combinationally.
  assign w_free          = c_depth - {1'b0, r_cnt};
  assign w_full          = (w_free < c_lanes_w);
  assign Full_out        = w_full;
  assign Almost_full_out = (w_free <= c_af_level);
  assign Empty_out       = (r_cnt == '0);
  assign Count_out       = r_cnt;
  assign Overflow_out    = r_ovf;
  assign Data_out        = r_dout;
  assign Data_valid      = r_dvalid;

  always_comb begin
    w_wr_n = '0;
    if (!w_full) begin
      w_wr_n = (WriteCnt_in > c_lanes) ? c_lanes : WriteCnt_in;
    end
  end

  assign w_rd_fire = ReadEn_in & ~stall & ~Empty_out;

  // Lane addresses never collide because WR_LANES <= DEPTH/2.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < WR_LANES; i++) begin
      if (CNT_W'(i) < w_wr_n) begin
        r_mem[r_wr_ptr + ADDRESS_WIDTH'(i)] <= Data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(w_wr_n);
      r_cnt    <= r_cnt + (ADDRESS_WIDTH+1)'(w_wr_n) - (ADDRESS_WIDTH+1)'(w_rd_fire);
      r_dvalid <= w_rd_fire;
      if (w_rd_fire) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_full && (WriteCnt_in != '0)) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_nw_1r.sv
// tb_fifo_nw_1r: directed self-checking bench for fifo_nw_1r (DEPTH=16, WR_LANES=2, AF_MARGIN=2).
`default_nettype none

module tb_fifo_nw_1r;

  logic         Clk = 1'b0;
  logic         Clear_in;
  logic [129:0] Data_in;
  logic [1:0]   WriteCnt_in;
  logic         Full_out, Almost_full_out, Overflow_out;
  logic         stall, ReadEn_in;
  logic [64:0]  Data_out;
  logic         Data_valid, Empty_out;
  logic [4:0]   Count_out;

  fifo_nw_1r #(
    .DATA_WIDTH(65), .ADDRESS_WIDTH(4), .WR_LANES(2), .AF_MARGIN(2)
  ) dut (
    .Clk(Clk), .Clear_in(Clear_in), .Data_in(Data_in), .WriteCnt_in(WriteCnt_in),
    .Full_out(Full_out), .Almost_full_out(Almost_full_out), .Overflow_out(Overflow_out),
    .stall(stall), .ReadEn_in(ReadEn_in), .Data_out(Data_out), .Data_valid(Data_valid),
    .Empty_out(Empty_out), .Count_out(Count_out)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          seq      = 0;
  string       phase    = "reset";
  logic [64:0] q[$];
  logic [64:0] m_dout   = '0;
  logic        m_ovf    = 1'b0;
  logic [64:0] first_val;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] mk(input int s);
    return {1'b1, 32'h5A5A_0000, 32'(s)};
  endfunction

  // One clock with the given request; model predicts, outputs sampled 1 time unit after the edge.
  task automatic cyc_d(input int wc, input bit rd, input bit st,
                       input logic [64:0] d0, input logic [64:0] d1);
    int cnt0;
    bit full;
    int wn;
    bit fire;
    cnt0 = q.size();
    full = (16 - cnt0) < 2;
    wn   = full ? 0 : ((wc > 2) ? 2 : wc);
    fire = rd && !st && (cnt0 != 0);
    WriteCnt_in = 2'(wc);
    ReadEn_in   = rd;
    stall       = st;
    Data_in     = {d1, d0};
    if (fire) m_dout = q.pop_front();
    if (wn >= 1) q.push_back(d0);
    if (wn >= 2) q.push_back(d1);
    if (full && wc != 0) m_ovf = 1'b1;
    @(posedge Clk);
    #1;
    chk("count", Count_out, q.size());
    chk("valid", Data_valid, fire);
    chk("dout",  Data_out, m_dout);
    chk("empty", Empty_out, q.size() == 0);
    chk("full",  Full_out, (16 - q.size()) < 2);
    chk("afull", Almost_full_out, (16 - q.size()) <= 4);
    chk("ovf",   Overflow_out, m_ovf);
    WriteCnt_in = '0;
    ReadEn_in   = 1'b0;
    stall       = 1'b0;
  endtask

  task automatic cyc(input int wc, input bit rd, input bit st);
    cyc_d(wc, rd, st, mk(seq), mk(seq + 1));
    seq += 2;
  endtask

  task automatic do_clear();
    Clear_in = 1'b1;
    @(posedge Clk);
    #1;
    Clear_in = 1'b0;
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    Clear_in = 1'b1; Data_in = '0; WriteCnt_in = '0; stall = 1'b0; ReadEn_in = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Clear_in = 1'b0;
    chk("empty", Empty_out, 1'b1);
    chk("count", Count_out, 5'd0);
    chk("valid", Data_valid, 1'b0);
    chk("dout",  Data_out, 65'd0);
    chk("full",  Full_out, 1'b0);
    chk("afull", Almost_full_out, 1'b0);
    chk("ovf",   Overflow_out, 1'b0);

    // Fill in pairs to 16, then drain back-to-back
    phase = "fill";
    first_val = mk(seq);
    for (int k = 1; k <= 8; k++) begin
      cyc(2, 0, 0);
      if (k == 5) chk("af_at10", Almost_full_out, 1'b0);
      if (k == 6) chk("af_at12", Almost_full_out, 1'b1);
      if (k == 7) chk("full_at14", Full_out, 1'b0);
    end
    chk("full_at16", Full_out, 1'b1);
    chk("count16", Count_out, 5'd16);
    phase = "drain";
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, 0);
      if (k == 1) chk("first_out", Data_out, first_val);
      if (k == 4) chk("af_at12", Almost_full_out, 1'b1);
      if (k == 5) chk("af_at11", Almost_full_out, 1'b0);
    end
    cyc(0, 1, 0);
    chk("rd_empty_cnt", Count_out, 5'd0);

    // Asynchronous clear at count 7, mid-cycle
    phase = "clear";
    repeat (4) cyc(2, 0, 0);
    cyc(0, 1, 0);
    #2;
    Clear_in = 1'b1;
    #1;
    chk("empty", Empty_out, 1'b1);
    chk("count", Count_out, 5'd0);
    chk("full",  Full_out, 1'b0);
    chk("valid", Data_valid, 1'b0);
    chk("dout",  Data_out, 65'd0);
    Clear_in = 1'b0;
    q.delete(); m_dout = '0; m_ovf = 1'b0;
    cyc(1, 0, 0);
    cyc(0, 1, 0);

    // Overflow: group dropped at count 15, flag sticky through drain
    phase = "ovf";
    repeat (7) cyc(2, 0, 0);
    cyc(1, 0, 0);
    chk("full_at15", Full_out, 1'b1);
    cyc_d(2, 0, 0, 65'hDEAD, 65'hBEEF);
    chk("count15", Count_out, 5'd15);
    chk("ovf_set", Overflow_out, 1'b1);
    repeat (16) cyc(0, 1, 0);
    chk("ovf_hold", Overflow_out, 1'b1);
    do_clear();
    chk("ovf_clr", Overflow_out, 1'b0);

    // Stall, empty read, simultaneous read/write
    phase = "stall";
    repeat (2) cyc(2, 0, 0);
    cyc(0, 1, 1);
    chk("stall_valid", Data_valid, 1'b0);
    chk("stall_cnt", Count_out, 5'd4);
    repeat (5) cyc(0, 1, 0);
    phase = "simul";
    repeat (5) cyc(2, 0, 0);
    cyc(2, 1, 0);
    chk("cnt11", Count_out, 5'd11);
    repeat (11) cyc(0, 1, 0);

    // Variable counts (3 clamps to 2) with stalls across several pointer wraps
    phase = "wrap";
    for (int i = 0; i < 60; i++) cyc(i % 4, 1'b1, (i % 7) == 3);
    repeat (20) cyc(0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_nw_1r.md
# fifo_nw_1r

Single-clock, parametrised multi-lane-write / single-read FIFO, the next generation of the pipeline's small logic-RAM FIFOs. A producer stage may push 0..WR_LANES entries per cycle, and a downstream consumer pops one entry per cycle under a stall signal. The block provides true full/empty detection, an occupancy count, almost-full back-pressure and a sticky overflow flag. It sits between SMEM extension stages, where a stage emits a variable number of results per cycle.

## Interface
- DATA_WIDTH, 65, bits per entry
- ADDRESS_WIDTH, 4, log2 of depth; DEPTH = 1<<ADDRESS_WIDTH; legal range 2..8
- WR_LANES, 2, maximum entries written per cycle; must satisfy 1 <= WR_LANES <= DEPTH/2
- AF_MARGIN, 2, Almost_full_out asserts when free entries <= AF_MARGIN + WR_LANES
- CNT_W, $clog2(WR_LANES+1), width of WriteCnt_in (derived)

- Clk  in  1  single clock, rising edge
- Clear_in  in  1  reset; asynchronous, active-high
- Data_in  in  WR_LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- WriteCnt_in  in  CNT_W  number of lanes to write this cycle; always lanes 0..WriteCnt_in-1; 0 = no write
- Full_out  out  1  free entries < WR_LANES; a write group is not accepted while high
- Almost_full_out  out  1  early back-pressure (see AF_MARGIN)
- Overflow_out  out  1  sticky; a nonzero write was presented while Full_out was high
- stall  in  1  downstream stall; blocks reads only
- ReadEn_in  in  1  pop request
- Data_out  out  DATA_WIDTH  registered read data
- Data_valid  out  1  Data_out carries a newly popped entry this cycle
- Empty_out  out  1  count == 0
- Count_out  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH x DATA_WIDTH register array in logic RAM style; binary write and read pointers of ADDRESS_WIDTH bits that wrap modulo DEPTH; occupancy register cnt.
- Write acceptance: wr_n = min(WriteCnt_in, WR_LANES) if !Full_out, else 0. Values above WR_LANES are clamped.
- Lane i < wr_n writes Mem[(wr_ptr+i) mod DEPTH]. wr_ptr advances by wr_n with wrap-around.
- Write while Full_out with WriteCnt_in != 0: the whole group is dropped (no partial write), Overflow_out sets and holds until Clear_in.
- Read acceptance: rd_fire = ReadEn_in & !stall & !Empty_out. On rd_fire, Data_out <= Mem[rd_ptr] and rd_ptr advances by 1.
- Data_valid <= rd_fire every cycle. When there is no fire, Data_out holds its previous value.
- cnt <= cnt + wr_n - rd_fire. Simultaneous read and write are always legal; cnt never exceeds DEPTH and never underflows.
- Flags are combinational from cnt only (no input-to-output paths):
  - Empty_out = (cnt == 0)
  - Full_out = (DEPTH - cnt < WR_LANES)
  - Almost_full_out = (DEPTH - cnt <= AF_MARGIN + WR_LANES)
- Read from empty: ignored, with no pointer or count change and no flag.
- No write-to-read bypass: an entry written at edge t is poppable from cycle t+1.

## Timing
- Reset values (async, immediate on Clear_in rise): wr_ptr=0, rd_ptr=0, cnt=0, Data_out=0, Data_valid=0, Overflow_out=0; hence Empty_out=1, Full_out=0, Almost_full_out=0, Count_out=0. Mem contents are not reset.
- Clear_in asserted mid-operation discards all contents; the first accepted write after deassertion lands at address 0.
- Read latency: rd_fire in cycle t -> Data_out/Data_valid valid in cycle t+1.
- Write to Empty_out deassert: 1 cycle. Write at cycle t to Data_valid: earliest cycle t+2.
- Full_out/Count_out reflect writes and reads accepted at the previous edge.
- Throughput: sustained WR_LANES writes and 1 read per cycle until Full_out.

## Test plan
- Reset/flags: after Clear_in pulse, Empty_out=1, Count_out=0, Data_valid=0, Data_out=0. Assert Clear_in mid-fill at cnt=7 -> all of these plus Full_out=0 immediately.
- Multi-lane fill (WR_LANES=2, DEPTH=16): write pairs {A0,A1},{A2,A3},... with WriteCnt_in=2 -> Full_out rises when cnt=15 or 16. Reading with ReadEn_in held returns A0,A1,... in order, one per cycle, Data_valid back-to-back.
- Variable count and wrap: mix WriteCnt_in=0,1,2,3 (3 clamps to 2) across three pointer wraps -> output order exactly equals lane-ordered input order; Count_out matches the scoreboard each cycle.
- Overflow: with cnt=15, present WriteCnt_in=2 with data 0xDEAD,0xBEEF -> nothing written, Count_out stays 15, Overflow_out=1 and remains 1 through later drain.
- Stall and empty: stall=1 with ReadEn_in=1 and cnt=4 -> Data_valid=0, Count_out stays 4. Read with cnt=0 -> no change. Simultaneous 2-write + 1-read at cnt=10 -> Count_out=11 next cycle.
- Almost-full: AF_MARGIN=2, DEPTH=16, WR_LANES=2 -> Almost_full_out rises exactly when cnt reaches 12 and falls when cnt drops to 11.
